// File: rtl/calc_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one bit per clock)
// with sign, leading-zero blank flags and a start/busy/done handshake.
module calc_bin2bcd_seq #(
  parameter bit SIGNED_MODE = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x,
  output logic       busy,
  output logic       done,
  output logic       neg,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic [2:0] blank
);

  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

  state_t      state;
  logic [7:0]  bin;
  logic [11:0] scratch;
  logic        sign_pend;
  logic [3:0]  count;

  logic        in_sign;
  logic [7:0]  mag;
  logic [11:0] adj;

  // 8'h80 negates to 8'h80, which is the correct unsigned magnitude 128.
  assign in_sign = SIGNED_MODE && x[7];
  assign mag     = in_sign ? (~x + 8'd1) : x;

  for (genvar d = 0; d < 3; d++) begin : g_add3
    assign adj[4*d +: 4] = (scratch[4*d +: 4] >= 4'd5) ? scratch[4*d +: 4] + 4'd3
                                                        : scratch[4*d +: 4];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bin       <= '0;
      scratch   <= '0;
      sign_pend <= 1'b0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      neg       <= 1'b0;
      bcd2      <= '0;
      bcd1      <= '0;
      bcd0      <= '0;
      blank     <= 3'b110;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin       <= mag;
            scratch   <= '0;
            sign_pend <= in_sign;
            count     <= '0;
            busy      <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          {scratch, bin} <= {adj, bin} << 1;
          count          <= count + 4'd1;
          if (count == 4'd7) state <= FINISH;
        end
        FINISH: begin
          bcd2  <= scratch[11:8];
          bcd1  <= scratch[7:4];
          bcd0  <= scratch[3:0];
          neg   <= sign_pend;
          blank <= {scratch[11:8] == 4'd0, scratch[11:4] == 8'd0, 1'b0};
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_bin2bcd_seq.sv
// Bench for calc_bin2bcd_seq: signed and unsigned instances share stimulus and are
// checked against an arithmetic digit model.
module tb_calc_bin2bcd_seq;

  logic       clock = 1'b0;
  logic       reset, start;
  logic [7:0] x;

  logic       busy_s, done_s, neg_s, busy_u, done_u, neg_u;
  logic [3:0] bcd2_s, bcd1_s, bcd0_s, bcd2_u, bcd1_u, bcd0_u;
  logic [2:0] blank_s, blank_u;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  calc_bin2bcd_seq #(.SIGNED_MODE(1'b1)) u_s (
    .clock(clock), .reset(reset), .start(start), .x(x),
    .busy(busy_s), .done(done_s), .neg(neg_s),
    .bcd2(bcd2_s), .bcd1(bcd1_s), .bcd0(bcd0_s), .blank(blank_s));

  calc_bin2bcd_seq #(.SIGNED_MODE(1'b0)) u_u (
    .clock(clock), .reset(reset), .start(start), .x(x),
    .busy(busy_u), .done(done_u), .neg(neg_u),
    .bcd2(bcd2_u), .bcd1(bcd1_u), .bcd0(bcd0_u), .blank(blank_u));

  // Packed result {neg, bcd2, bcd1, bcd0, blank} computed from decimal arithmetic.
  function automatic logic [15:0] model(input logic [7:0] v, input bit sm);
    int m, d2, d1, d0;
    logic sg;
    sg = sm && (v >= 8'd128);
    m  = sg ? 256 - int'(v) : int'(v);
    d2 = m / 100;
    d1 = (m / 10) % 10;
    d0 = m % 10;
    return {sg, 4'(d2), 4'(d1), 4'(d0), d2 == 0, (d2 == 0) && (d1 == 0), 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] es, input logic [15:0] eu);
    chk({tag, "_s"}, {neg_s, bcd2_s, bcd1_s, bcd0_s, blank_s}, es);
    chk({tag, "_u"}, {neg_u, bcd2_u, bcd1_u, bcd0_u, blank_u}, eu);
  endtask

  // One conversion: start pulsed for the accepting edge, x scrambled while busy,
  // optional ignored re-start at cycle 3, result expected on the 9th edge after accept.
  task automatic convert(input logic [7:0] v, input bit poke);
    logic [15:0] hold_s, hold_u;
    hold_s = {neg_s, bcd2_s, bcd1_s, bcd0_s, blank_s};
    hold_u = {neg_u, bcd2_u, bcd1_u, bcd0_u, blank_u};
    x = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("busy_c%0d", c), {12'd0, busy_s, busy_u, done_s, done_u}, 16'h000C);
      if (c == 5) chk_out("hold", hold_s, hold_u);
      x = 8'($urandom);
      start = poke && (c == 3);
      if (start) x = 8'd12;
      if (c < 9) tick();
    end
    start = 1'b0;
    tick();
    chk("done", {12'd0, busy_s, busy_u, done_s, done_u}, 16'h0003);
    chk_out($sformatf("res_%0d", v), model(v, 1'b1), model(v, 1'b0));
  endtask

  initial begin
    logic [7:0] dir [7];
    dir = '{8'd127, 8'h80, 8'hFB, 8'd0, 8'd40, 8'hFF, 8'd7};
    reset = 1'b1;
    start = 1'b0;
    x     = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_out("reset", 16'h0006, 16'h0006);
    chk("reset_ctl", {12'd0, busy_s, busy_u, done_s, done_u}, 16'h0000);

    foreach (dir[i]) begin
      convert(dir[i], 1'b0);
      tick();
      chk("done_1cyc", {14'd0, done_s, done_u}, 16'h0000);
    end

    // Ignored mid-flight start, then back-to-back accept in the done cycle.
    convert(8'd99, 1'b1);
    convert(8'd12, 1'b0);

    for (int n = 0; n < 20; n++) convert(8'($urandom), 1'b0);

    // Reset during a conversion aborts it with no done pulse.
    x = 8'd55;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_out("rst_abort", 16'h0006, 16'h0006);
    chk("rst_abort_ctl", {12'd0, busy_s, busy_u, done_s, done_u}, 16'h0000);
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
        tick();
        seen = seen | done_s | done_u | busy_s | busy_u;
      end
      chk("no_done_after_rst", {15'd0, seen}, 16'h0000);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
